// File: rtl/toggle_meas_pkg.sv
// toggle_meas_pkg: shared state type, default sizes and saturation helper for the toggle period meter
package toggle_meas_pkg;
  typedef enum logic {IDLE, MEASURE} state_t;
  localparam int CNT_W_DEF = 24;
  localparam int SYNC_STAGES_DEF = 2;
  function automatic logic [63:0] cnt_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser with registered rise/fall detection
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic s,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic p;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      p    <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      p    <= sync[SYNC_STAGES-1];
    end
  end
  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~p;
  assign fall = ~s & p;
endmodule

// File: rtl/toggle_period_meter.sv
// toggle_period_meter: measures rising-to-rising period and high time of an asynchronous input in clk cycles
module toggle_period_meter
  import toggle_meas_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             timeout
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, hi_latch, hi_n, per_n, ht_n;
  logic vld_n, to_n, rise, fall;
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .s    (),
    .rise (rise),
    .fall (fall)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      hi_latch     <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      hi_latch     <= hi_n;
      period       <= per_n;
      high_time    <= ht_n;
      period_valid <= vld_n;
      timeout      <= to_n;
    end
  end
  // clr outranks everything; a rise ends one measurement and starts the next
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi_latch;
    per_n   = period;
    ht_n    = high_time;
    vld_n   = 1'b0;
    to_n    = timeout;
    if (clr) begin
      state_n = IDLE;
      cnt_n   = '0;
      hi_n    = '0;
      per_n   = '0;
      ht_n    = '0;
      to_n    = 1'b0;
    end else if (state == IDLE) begin
      cnt_n   = rise ? CNT_W'(1) : cnt;
      state_n = rise ? MEASURE : IDLE;
    end else if (rise) begin
      per_n = cnt;
      ht_n  = hi_latch;
      vld_n = 1'b1;
      to_n  = 1'b0;
      cnt_n = CNT_W'(1);
    end else if (cnt == CNT_MAX) begin
      to_n    = 1'b1;
      state_n = IDLE;
    end else begin
      cnt_n = cnt + CNT_W'(1);
      hi_n  = fall ? cnt : hi_latch;
    end
  end
endmodule

// File: tb/tb_toggle_period_meter.sv
// tb_toggle_period_meter: directed checks of period/high-time measurement, timeout, clr and async reset
module tb_toggle_period_meter;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, din = 1'b0, clr = 1'b0;
  logic [W-1:0] period, high_time;
  logic period_valid, timeout;
  int tests = 0, fails = 0;
  int cyc = 0, nstr = 0, last_cyc = 0, last_gap = 0, base = 0;
  logic prev_v = 1'b0;

  toggle_period_meter #(.CNT_W(W), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .clr         (clr),
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (period_valid && prev_v) check("no_back_to_back", 32'(prev_v), 32'd0);
    if (period_valid) begin
      nstr++;
      last_gap = cyc - last_cyc;
      last_cyc = cyc;
    end
    prev_v = period_valid;
  end

  task automatic wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      din = 1'b1;
      repeat (hi) @(negedge clk);
      din = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic do_clr();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  initial begin
    repeat (3) begin
      @(negedge clk) din = ~din;
    end
    check("rst_period", 32'(period), 0);
    check("rst_high", 32'(high_time), 0);
    check("rst_valid", 32'(period_valid), 0);
    check("rst_timeout", 32'(timeout), 0);
    din = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    base = nstr;
    wave(5, 5, 4);
    check("sq_strobes", 32'(nstr - base), 3);
    check("sq_period", 32'(period), 10);
    check("sq_high", 32'(high_time), 5);
    check("sq_gap", 32'(last_gap), 10);

    base = nstr;
    repeat (300) @(negedge clk);
    check("to_flag", 32'(timeout), 1);
    check("to_no_strobe", 32'(nstr - base), 0);
    check("to_hold_period", 32'(period), 10);
    check("to_hold_high", 32'(high_time), 5);
    base = nstr;
    wave(4, 4, 2);
    check("rearm_strobes", 32'(nstr - base), 1);
    check("rearm_period", 32'(period), 8);
    check("rearm_high", 32'(high_time), 4);
    check("rearm_timeout", 32'(timeout), 0);

    do_clr();
    repeat (3) @(negedge clk);
    base = nstr;
    wave(3, 9, 4);
    check("asym_strobes", 32'(nstr - base), 3);
    check("asym_period", 32'(period), 12);
    check("asym_high", 32'(high_time), 3);
    check("asym_gap", 32'(last_gap), 12);

    do_clr();
    base = nstr;
    din = 1'b1;
    repeat (300) @(negedge clk);
    check("stuck_timeout", 32'(timeout), 1);
    check("stuck_no_strobe", 32'(nstr - base), 0);
    check("stuck_period", 32'(period), 0);

    do_clr();
    din = 1'b0;
    repeat (4) @(negedge clk);
    wave(5, 5, 3);
    check("pre_clr_period", 32'(period), 10);
    base = nstr;
    din = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    repeat (4) @(negedge clk);
    check("clr_rise_no_strobe", 32'(nstr - base), 0);
    check("clr_period", 32'(period), 0);
    check("clr_high", 32'(high_time), 0);
    din = 1'b0;
    repeat (6) @(negedge clk);
    base = nstr;
    wave(5, 5, 2);
    check("post_clr_strobes", 32'(nstr - base), 1);
    check("post_clr_period", 32'(period), 10);

    din = 1'b1;
    repeat (9) @(negedge clk);
    check("pre_rst_period", 32'(period), 10);
    rst_n = 1'b0;
    din = 1'b0;
    #1;
    check("async_period", 32'(period), 0);
    check("async_high", 32'(high_time), 0);
    check("async_valid", 32'(period_valid), 0);
    check("async_timeout", 32'(timeout), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    base = nstr;
    wave(6, 6, 3);
    check("rst_rec_strobes", 32'(nstr - base), 2);
    check("rst_rec_period", 32'(period), 12);
    check("rst_rec_high", 32'(high_time), 6);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
